// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR write-burst path: FSM states, AXI field widths
// and response codes.
package ddr_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } wr_state_e;

  localparam int unsigned AXI_LEN_W  = 8;
  localparam logic [1:0]  BRESP_OKAY = 2'b00;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/wbeat_skid.sv
// Two-entry register FIFO between the video FIFO read port and the AXI W channel.
// Entry 0 is always the head, so the W data output comes straight from a register.
module wbeat_skid #(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent1_q;
  logic [1:0]            occ_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= '0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= data_i;
          else               ent1_q <= data_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word lands behind the survivor.
          if (occ_q == 2'd1) begin
            ent0_q <= data_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = ent0_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// Drains the video write FIFO into fixed-length AXI4 INCR write bursts over a
// linear frame buffer, wrapping to the frame base after each full frame.
module ddr_wr_burst_ctrl
  import ddr_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned LEVEL_WIDTH = 11,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_BASE  = 0,
  parameter int unsigned FRAME_WORDS = 57600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  output logic                      fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  input  logic                      fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0]    fifo_rd_level,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [AXI_LEN_W-1:0]      m_awlen,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic                      m_bvalid,
  input  logic [1:0]                m_bresp,
  output logic                      m_bready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      wr_err
);

  if ((FRAME_WORDS % BURST_LEN) != 0 || BURST_LEN == 0 || BURST_LEN > 256) begin : g_param_chk
    $error("ddr_wr_burst_ctrl: FRAME_WORDS must be a multiple of BURST_LEN and BURST_LEN in 1..256");
  end

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned CNT_W  = $clog2(FRAME_WORDS + 1);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(FRAME_BASE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_LEN * bytes_per_beat(DATA_WIDTH));
  localparam logic [BEAT_W-1:0]     BEATS      = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]      CNT_STEP   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]      FRAME_LAST = CNT_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [LEVEL_WIDTH-1:0] LVL_MIN   = LEVEL_WIDTH'(BURST_LEN);

  wr_state_e              state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CNT_W-1:0]       frame_cnt_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [BEAT_W-1:0]      rd_cnt_q;
  logic                   rd_inflight_q;
  logic                   restart_q;
  logic                   awvalid_q;
  logic                   bready_q;
  logic                   frame_done_q;
  logic                   wr_err_q;

  logic                   skid_valid;
  logic [DATA_WIDTH-1:0]  skid_data;
  logic [1:0]             skid_occ;
  logic                   w_hs;
  logic                   wlast;
  logic [2:0]             credit;
  logic                   rd_en;

  wbeat_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rd_inflight_q),
    .data_i  (fifo_rd_data),
    .pop_i   (w_hs),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .occ_o   (skid_occ)
  );

  assign w_hs  = skid_valid & m_wready;
  assign wlast = skid_valid & (beat_q == LAST_BEAT);

  // Credit counts the beat popped this cycle as free, which sustains one read per clock.
  always_comb begin
    credit = 3'(skid_occ) + 3'(rd_inflight_q) - 3'(w_hs);
    rd_en  = 1'b0;
    if (state_q == ST_W && rd_cnt_q != BEATS && !fifo_rd_empty && credit < 3'd2)
      rd_en = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= BASE_ADDR;
      frame_cnt_q   <= '0;
      beat_q        <= '0;
      rd_cnt_q      <= '0;
      rd_inflight_q <= 1'b0;
      restart_q     <= 1'b0;
      awvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      rd_inflight_q <= rd_en;
      if (rd_en) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (w_hs)  beat_q   <= beat_q + 1'b1;
      if (frame_start && state_q != ST_IDLE) restart_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            addr_q      <= BASE_ADDR;
            frame_cnt_q <= '0;
          end
          if (fifo_rd_level >= LVL_MIN && !restart_q) begin
            state_q   <= ST_AW;
            awvalid_q <= 1'b1;
          end
        end
        ST_AW: begin
          if (m_awready) begin
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            rd_cnt_q  <= '0;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs && wlast) begin
            bready_q <= 1'b1;
            state_q  <= ST_B;
          end
        end
        ST_B: begin
          if (m_bvalid) begin
            bready_q  <= 1'b0;
            restart_q <= 1'b0;
            state_q   <= ST_IDLE;
            if (m_bresp != BRESP_OKAY) wr_err_q <= 1'b1;
            // A frame wrap and a pending restart both land on the base; only the wrap reports done.
            if (frame_cnt_q == FRAME_LAST) begin
              addr_q       <= BASE_ADDR;
              frame_cnt_q  <= '0;
              frame_done_q <= 1'b1;
            end else if (restart_q || frame_start) begin
              addr_q      <= BASE_ADDR;
              frame_cnt_q <= '0;
            end else begin
              addr_q      <= addr_q + ADDR_STEP;
              frame_cnt_q <= frame_cnt_q + CNT_STEP;
            end
          end
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_awaddr   = addr_q;
  assign m_awlen    = AXI_LEN_W'(BURST_LEN - 1);
  assign m_awvalid  = awvalid_q;
  assign m_wdata    = skid_data;
  assign m_wstrb    = '1;
  assign m_wlast    = wlast;
  assign m_wvalid   = skid_valid;
  assign m_bready   = bready_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Random-backpressure bench for ddr_wr_burst_ctrl with a queue-based FIFO and a
// burst/frame address reference model.
module tb_ddr_wr_burst_ctrl;

  localparam int unsigned AW   = 28;
  localparam int unsigned DW   = 256;
  localparam int unsigned LW   = 11;
  localparam int unsigned BL   = 16;
  localparam int unsigned FW   = 64;
  localparam int unsigned STEP = BL * DW / 8;
  localparam logic [AW-1:0] BASE = '0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_rd_data = '0;
  logic            fifo_rd_empty = 1'b1;
  logic [LW-1:0]   fifo_rd_level = '0;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic            m_awvalid;
  logic            m_awready = 1'b0;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wlast, m_wvalid;
  logic            m_wready = 1'b0;
  logic            m_bvalid = 1'b0;
  logic [1:0]      m_bresp = 2'b00;
  logic            m_bready, busy, frame_done, wr_err;

  always #5 clk = ~clk;

  ddr_wr_burst_ctrl #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .LEVEL_WIDTH (LW),
    .BURST_LEN   (BL),
    .FRAME_BASE  (0),
    .FRAME_WORDS (FW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_level (fifo_rd_level),
    .m_awaddr      (m_awaddr),
    .m_awlen       (m_awlen),
    .m_awvalid     (m_awvalid),
    .m_awready     (m_awready),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_wlast       (m_wlast),
    .m_wvalid      (m_wvalid),
    .m_wready      (m_wready),
    .m_bvalid      (m_bvalid),
    .m_bresp       (m_bresp),
    .m_bready      (m_bready),
    .busy          (busy),
    .frame_done    (frame_done),
    .wr_err        (wr_err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Handshakes and sampled values as seen by the DUT at each rising edge.
  logic          rd_fire_s = 1'b0, empty_s = 1'b1, rst_s = 1'b1, fs_s = 1'b0;
  logic          aw_hs_s = 1'b0, w_hs_s = 1'b0, wlast_s = 1'b0, wvalid_s = 1'b0, b_hs_s = 1'b0;
  logic [AW-1:0] awaddr_s = '0;
  logic [7:0]    awlen_s = '0;
  logic [DW-1:0] wdata_s = '0;
  logic [1:0]    bresp_s = '0;

  always @(posedge clk) begin
    rd_fire_s <= fifo_rd_en;
    empty_s   <= fifo_rd_empty;
    rst_s     <= rst;
    fs_s      <= frame_start;
    aw_hs_s   <= m_awvalid & m_awready;
    awaddr_s  <= m_awaddr;
    awlen_s   <= m_awlen;
    w_hs_s    <= m_wvalid & m_wready;
    wlast_s   <= m_wlast;
    wvalid_s  <= m_wvalid;
    wdata_s   <= m_wdata;
    b_hs_s    <= m_bvalid & m_bready;
    bresp_s   <= m_bresp;
  end

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   push_total = 0, pushed = 0;
  int unsigned   aw_prob = 100, w_prob = 100, b_prob = 100;
  int unsigned   cyc = 0;
  logic [AW-1:0] exp_addr = '0;
  int unsigned   exp_cnt = 0;
  bit            restart_pend = 1'b0, in_burst = 1'b0, exp_err = 1'b0;
  int unsigned   beat_idx = 0, rd_cnt = 0, b_total = 0, aw_total = 0, fd_count = 0;
  int unsigned   err_burst = 1000, w_first = 0, w_last = 0;

  always @(negedge clk) begin
    logic [DW-1:0] w;
    bit            fd_exp;
    cyc++;
    fd_exp = 1'b0;
    if (rd_fire_s) begin
      check_eq("rd_while_empty", 256'(empty_s), 256'(1'b0));
      if (fq.size() != 0) begin
        w = fq.pop_front();
        fifo_rd_data = w;
        if (!rst_s) exp_q.push_back(w);
      end
    end
    if (rst_s) begin
      exp_q.delete();
      exp_addr = BASE; exp_cnt = 0; restart_pend = 1'b0; in_burst = 1'b0;
      exp_err = 1'b0; beat_idx = 0; rd_cnt = 0;
    end else begin
      if (wvalid_s && !w_hs_s) begin
        check_eq("w_hold_valid", 256'(m_wvalid), 256'(1'b1));
        check_eq("w_hold_data", 256'(m_wdata), 256'(wdata_s));
      end
      if (fs_s) begin
        if (in_burst) restart_pend = 1'b1;
        else begin exp_addr = BASE; exp_cnt = 0; end
      end
      if (aw_hs_s) begin
        check_eq("awaddr", 256'(awaddr_s), 256'(exp_addr));
        check_eq("awlen", 256'(awlen_s), 256'(BL - 1));
        in_burst = 1'b1; beat_idx = 0; rd_cnt = 0; aw_total++;
      end
      if (rd_fire_s) rd_cnt++;
      if (w_hs_s) begin
        if (exp_q.size() == 0) check_eq("w_beat_available", 256'(exp_q.size()), 256'(1));
        else check_eq("wdata_order", 256'(wdata_s), 256'(exp_q.pop_front()));
        if (beat_idx == 0) w_first = cyc;
        w_last = cyc;
        check_eq("wlast", 256'(wlast_s), 256'(beat_idx == BL - 1));
        beat_idx++;
        if (beat_idx == BL) check_eq("bready_after_wlast", 256'(m_bready), 256'(1'b1));
      end
      if (b_hs_s) begin
        check_eq("beats_per_burst", 256'(beat_idx), 256'(BL));
        check_eq("reads_per_burst", 256'(rd_cnt), 256'(BL));
        if (bresp_s != 2'b00) exp_err = 1'b1;
        b_total++;
        in_burst = 1'b0;
        exp_cnt += BL;
        if (exp_cnt == FW) begin exp_addr = BASE; exp_cnt = 0; fd_exp = 1'b1; end
        else if (restart_pend) begin exp_addr = BASE; exp_cnt = 0; end
        else exp_addr = exp_addr + AW'(STEP);
        restart_pend = 1'b0;
        check_eq("wr_err", 256'(wr_err), 256'(exp_err));
      end
      if (frame_done || fd_exp) check_eq("frame_done", 256'(frame_done), 256'(fd_exp));
      if (frame_done) fd_count++;
    end
    while (pushed < push_total) begin
      fq.push_back(rand_word());
      pushed++;
    end
    fifo_rd_level = LW'(fq.size());
    fifo_rd_empty = (fq.size() == 0);
    m_awready = ($urandom_range(99) < aw_prob);
    m_wready  = ($urandom_range(99) < w_prob);
    if (b_hs_s || rst_s) m_bvalid = 1'b0;
    else if (m_bready && !m_bvalid && $urandom_range(99) < b_prob) begin
      m_bvalid = 1'b1;
      m_bresp  = (b_total == err_burst) ? 2'b10 : 2'b00;
    end
  end

  task automatic wait_b(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (b_total < n && k < budget) begin @(negedge clk); k++; end
    check_eq("wait_bursts", 256'(b_total), 256'(n));
  endtask

  task automatic wait_beats(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (!(in_burst && beat_idx >= n) && k < budget) begin @(negedge clk); k++; end
    check_eq("wait_in_w", 256'(in_burst), 256'(1'b1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_awvalid", 256'(m_awvalid), 256'(1'b0));
    check_eq("rst_wvalid", 256'(m_wvalid), 256'(1'b0));
    check_eq("rst_rd_en", 256'(fifo_rd_en), 256'(1'b0));
    check_eq("rst_bready", 256'(m_bready), 256'(1'b0));
    check_eq("rst_busy", 256'(busy), 256'(1'b0));
    check_eq("rst_frame_done", 256'(frame_done), 256'(1'b0));
    check_eq("rst_wr_err", 256'(wr_err), 256'(1'b0));
    check_eq("rst_awaddr", 256'(m_awaddr), 256'(BASE));
    check_eq("rst_awlen", 256'(m_awlen), 256'(BL - 1));
    check_eq("rst_wstrb", 256'(m_wstrb), 256'({(DW/8){1'b1}}));
    rst = 1'b0;

    push_total = 15;
    repeat (20) begin
      @(negedge clk);
      check_eq("no_aw_at_15", 256'(m_awvalid), 256'(1'b0));
      check_eq("idle_at_15", 256'(busy), 256'(1'b0));
    end

    push_total = 16;
    wait_b(1, 200);
    check_eq("beats_consecutive", 256'(w_last - w_first), 256'(BL - 1));

    aw_prob = 50; w_prob = 50; b_prob = 50;
    push_total = 64;
    wait_b(4, 3000);
    repeat (3) @(negedge clk);
    check_eq("frame_done_count", 256'(fd_count), 256'(1));

    err_burst = 4;
    push_total = 80;
    wait_b(5, 1000);

    push_total = 96;
    wait_beats(3, 1000);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_b(6, 1000);
    push_total = 112;
    wait_b(7, 1000);
    check_eq("no_done_on_restart", 256'(fd_count), 256'(1));

    repeat (5) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    push_total = 128;
    wait_b(8, 1000);

    push_total = 144;
    wait_beats(5, 1000);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_awvalid", 256'(m_awvalid), 256'(1'b0));
    check_eq("mid_rst_wvalid", 256'(m_wvalid), 256'(1'b0));
    check_eq("mid_rst_rd_en", 256'(fifo_rd_en), 256'(1'b0));
    check_eq("mid_rst_busy", 256'(busy), 256'(1'b0));
    check_eq("mid_rst_wr_err", 256'(wr_err), 256'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    push_total = 160;
    wait_b(9, 1000);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
